sisc_mc_core: RTL and testbench
===============================

Name: sisc_mc_core

Overview:
- Parametrised multi-cycle SISC execution core: one instruction accepted per ready/valid handshake, then sequenced through DECODE, EXEC and WB states.
- Contains a register file of NREGS x WIDTH, a 4-bit status register (C,N,V,Z) and an 8-function ALU.
- Has a non-intrusive debug read port.
- Successor to the fixed 32-bit single-path SISC datapath: adds width/depth generalisation, immediates, a halt state, illegal-opcode flagging and an input handshake.

Parameters:
- WIDTH, 32, data/register width in bits; legal range 16..64.
- NREGS, 16, number of architectural registers; legal range 2..16; index fields are 4 bits.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst_f  input  1  asynchronous active-low reset.
- ir  input  32  instruction word; sampled only on handshake.
- ir_valid  input  1  ir holds a valid instruction.
- ir_ready  output  1  core can accept an instruction.
- done  output  1  one-cycle pulse when an instruction retires.
- halted  output  1  core is in HALT.
- illegal  output  1  sticky: undefined opcode seen.
- stat  output  4  status register {C,N,V,Z}.
- dbg_addr  input  4  debug register index.
- dbg_data  output  WIDTH  combinational read of reg[dbg_addr]; 0 if dbg_addr >= NREGS or dbg_addr == 0.

Behaviour:
- Reset (rst_f low, asynchronous): state=IDLE, all registers=0, stat=0, illegal=0, done=0, halted=0. ir_ready is 0 while rst_f is low and 1 in the first cycle after release. Reset mid-instruction aborts it; no write occurs.
- Instruction fields:
  - [31:28] opcode
  - [27:24] fn
  - [23:20] rd
  - [19:16] rs
  - [15:12] rt
  - [15:0] imm, zero-extended to WIDTH
- Opcodes:
  - 0x0 NOP
  - 0x1 ALU reg-reg: B = reg[rt]
  - 0x2 ALU immediate: B = imm
  - 0xF HLT
  - all others illegal
- fn encoding: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT (~A), 6 SHL, 7 SHR (logical). fn 8..15 is treated as illegal.
- A = reg[rs]. reg[0] reads 0 and ignores writes. Indices >= NREGS read 0 and ignore writes.
- FSM, normal build, 4 cycles per ALU instruction:
  - IDLE: ir_ready=1. On ir_valid&&ir_ready, latch ir and go to DECODE.
  - DECODE: read A/B into operand latches. Illegal opcode or fn: set illegal, go to WB with no write. HLT: go to HALT. Otherwise go to EXEC.
  - EXEC: compute the result into the result latch and update stat, for ALU ops only. NOP skips the stat update.
  - WB: write the result to rd for ALU ops; done=1 for one cycle; go to IDLE.
  - HALT: halted=1, ir_ready=0, done never asserts. Exit only by reset.
- Status rules:
  - Z = (result==0); N = result[WIDTH-1].
  - ADD: C = carry out; V = signed overflow.
  - SUB: computed as A+~B+1; C = no-borrow (A >= B unsigned); V = signed overflow.
  - AND/OR/XOR/NOT: C=0, V=0.
  - Shifts: amount = B[SHW-1:0]; C = last bit shifted out, or 0 if amount==0; V=0.
- Results are truncated to WIDTH. imm is truncated if WIDTH < 16; not applicable, since WIDTH >= 16.
- Back-to-back: ir_ready returns in the cycle after WB, so the peak rate is 1 instruction per 4 cycles. ir_valid while not ready is ignored; ir is not latched.
- Debug read during WB returns the old value in the WB cycle and the new value from the next cycle.
- Simultaneous: an instruction with rd==rs reads the pre-write value, because operands are latched in DECODE.

Optional Feature:
- SISC_FAST_WB_EN defined: EXEC and WB merge into one state. The register write, stat update and done pulse all occur in EXEC. ALU instructions take 3 cycles; illegal instructions retire from DECODE with done in the next cycle.
- Undefined: the 4-cycle sequence above.
- Status semantics are identical in both builds.

Test Plan:
- Reset, then ir=0x2_0_1_0_0005 (ADDI r1=r0+5) -> done 4 cycles after the handshake (3 with SISC_FAST_WB_EN); dbg_addr=1 -> dbg_data=5; stat=0000.
- r1=5; SUB r2=r1-r1 (ir=0x1_1_2_1_1000) -> reg2=0, stat Z=1, C=1, N=0, V=0.
- ADDI r3=0x7FFF then ADD r4=r3+r3 with WIDTH=16 -> reg4=0xFFFE, N=1, V=1, C=0.
- SHL by 1 of 0x8000_0001 (WIDTH=32) -> result 0x0000_0002, C=1; SHR by 0 -> result unchanged, C=0.
- ir opcode 0x5 -> illegal=1 sticky, done pulses, no register changes, stat unchanged; a following valid ADDI still executes.
- HLT, then assert ir_valid with ADDI -> halted=1, ir_ready=0, no done; assert rst_f=0 mid-EXEC of another run -> all outputs 0 immediately and the pending write is lost.

Source files
------------

// File: rtl/sisc_mc_core.sv
// sisc_mc_core: multi-cycle SISC execution core (IDLE/DECODE/EXEC/WB/HALT).
// Register file NREGS x WIDTH, 4-bit status {C,N,V,Z}, 8-function ALU,
// combinational debug read port.
// Build option: define SISC_FAST_WB_EN to merge EXEC and WB into a single
// EXEC state (register write, status update and done all in EXEC).
module sisc_mc_core #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic [31:0]      ir,
  input  logic             ir_valid,
  output logic             ir_ready,
  output logic             done,
  output logic             halted,
  output logic             illegal,
  output logic [3:0]       stat,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t state, state_nx;

  logic [31:0]      ir_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             wr_q;
  logic             ill_q;
  logic [3:0]       stat_q;
  logic [WIDTH-1:0] regs [16];
`ifndef SISC_FAST_WB_EN
  logic [WIDTH-1:0] res_q;
`endif

  logic [3:0]       opc, fn, rd, rs, rt;
  logic [WIDTH-1:0] imm_ext, a_rd, b_rd, dbg_rd;
  logic             dec_alu, dec_halt, dec_illegal, rd_ok;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   alu_wide;
  logic [SHW-1:0]   sh_amt;
  logic [3:0]       alu_flags;

  assign opc     = ir_q[31:28];
  assign fn      = ir_q[27:24];
  assign rd      = ir_q[23:20];
  assign rs      = ir_q[19:16];
  assign rt      = ir_q[15:12];
  assign imm_ext = WIDTH'(ir_q[15:0]);

  assign dec_alu     = ((opc == 4'h1) || (opc == 4'h2)) && !fn[3];
  assign dec_halt    = (opc == 4'hF);
  assign dec_illegal = !((opc == 4'h0) || dec_halt || dec_alu);

  // reg[0] and indices beyond NREGS read as zero and are never written
  assign rd_ok  = (rd != 4'd0) && (32'(rd) < NREGS);
  assign a_rd   = ((rs != 4'd0) && (32'(rs) < NREGS)) ? regs[rs] : '0;
  assign b_rd   = ((rt != 4'd0) && (32'(rt) < NREGS)) ? regs[rt] : '0;
  assign dbg_rd = ((dbg_addr != 4'd0) && (32'(dbg_addr) < NREGS)) ? regs[dbg_addr] : '0;

  assign dbg_data = dbg_rd;
  assign illegal  = ill_q;
  assign stat     = stat_q;
  assign sh_amt   = b_q[SHW-1:0];

  // ALU on the latched operands; shifts use a one-bit-wider datapath so the
  // last bit shifted out lands in the extra bit (zero when the amount is zero)
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    case (fn[2:0])
      3'd0: begin
        alu_wide = {1'b0, a_q} + {1'b0, b_q};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
        alu_v    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'd1: begin
        alu_wide = {1'b0, a_q} + {1'b0, ~b_q} + ONE;
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
        alu_v    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_res[WIDTH-1] != a_q[WIDTH-1]);
      end
      3'd2: alu_res = a_q & b_q;
      3'd3: alu_res = a_q | b_q;
      3'd4: alu_res = a_q ^ b_q;
      3'd5: alu_res = ~a_q;
      3'd6: begin
        alu_wide = {1'b0, a_q} << sh_amt;
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      3'd7: begin
        alu_wide = {a_q, 1'b0} >> sh_amt;
        alu_res  = alu_wide[WIDTH:1];
        alu_c    = alu_wide[0];
      end
      default: ;
    endcase
  end

  assign alu_flags = {alu_c, alu_res[WIDTH-1], alu_v, (alu_res == '0)};

  // state register
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next state and handshake/status outputs
  always_comb begin
    state_nx = state;
    ir_ready = 1'b0;
    done     = 1'b0;
    halted   = 1'b0;
    case (state)
      S_IDLE: begin
        ir_ready = rst_f;
        if (ir_valid && rst_f) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (dec_halt) state_nx = S_HALT;
`ifdef SISC_FAST_WB_EN
        else          state_nx = S_EXEC;
`else
        else if (dec_illegal) state_nx = S_WB;
        else                  state_nx = S_EXEC;
`endif
      end
      S_EXEC: begin
`ifdef SISC_FAST_WB_EN
        done     = 1'b1;
        state_nx = S_IDLE;
`else
        state_nx = S_WB;
`endif
      end
      S_WB: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      S_HALT: halted = 1'b1;
      default: state_nx = S_IDLE;
    endcase
  end

  // instruction/operand latches, status, sticky illegal and register file
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      ir_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      wr_q   <= 1'b0;
      ill_q  <= 1'b0;
      stat_q <= '0;
`ifndef SISC_FAST_WB_EN
      res_q  <= '0;
`endif
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ir_valid) ir_q <= ir;
        end
        S_DECODE: begin
          a_q  <= a_rd;
          b_q  <= (opc == 4'h1) ? b_rd : imm_ext;
          wr_q <= dec_alu;
          if (dec_illegal) ill_q <= 1'b1;
        end
        S_EXEC: begin
          if (wr_q) begin
            stat_q <= alu_flags;
`ifdef SISC_FAST_WB_EN
            if (rd_ok) regs[rd] <= alu_res;
`else
            res_q <= alu_res;
`endif
          end
        end
`ifndef SISC_FAST_WB_EN
        S_WB: begin
          if (wr_q && rd_ok) regs[rd] <= res_q;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_mc_core.sv
module tb_sisc_mc_core;

`ifdef SISC_FAST_WB_EN
  localparam int ALU_LAT = 3;
`else
  localparam int ALU_LAT = 4;
`endif
  localparam int ILL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_f;
  logic [31:0] ir;
  logic        ir_valid;
  logic [3:0]  dbg_addr;

  logic        ir_ready, done, halted, illegal;
  logic [3:0]  stat;
  logic [31:0] dbg32;

  logic        r16_ready, d16_done, h16, i16;
  logic [3:0]  stat16;
  logic [15:0] dbg16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sisc_mc_core #(.WIDTH(32), .NREGS(16)) u_dut (
    .clk(clk), .rst_f(rst_f), .ir(ir), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .done(done), .halted(halted), .illegal(illegal),
    .stat(stat), .dbg_addr(dbg_addr), .dbg_data(dbg32)
  );

  sisc_mc_core #(.WIDTH(16), .NREGS(16)) u_dut16 (
    .clk(clk), .rst_f(rst_f), .ir(ir), .ir_valid(ir_valid),
    .ir_ready(r16_ready), .done(d16_done), .halted(h16), .illegal(i16),
    .stat(stat16), .dbg_addr(dbg_addr), .dbg_data(dbg16)
  );

  // Issue one instruction; lat counts the handshake cycle as cycle 1.
  task automatic exec(input logic [31:0] instr, output int lat, output logic done_next,
                      output logic ready_next, output logic [31:0] dbg_at_done);
    int n;
    lat = 0; done_next = 1'b0; ready_next = 1'b0; dbg_at_done = '0;
    @(negedge clk);
    ir = instr; ir_valid = 1'b1;
    n = 0;
    while (ir_ready !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    ir_valid = 1'b0; ir = 32'h5A5A_5A5A;
    n = 2;
    while (done !== 1'b1 && n < 12) begin @(posedge clk); #1; n++; end
    if (done === 1'b1) begin
      lat = n;
      dbg_at_done = dbg32;
      @(posedge clk); #1;
      done_next = done;
      ready_next = ir_ready;
    end
  endtask

  task automatic test_reset;
    rst_f = 1'b0; ir_valid = 1'b0; ir = '0; dbg_addr = 4'd1;
    repeat (3) @(negedge clk);
    checks++; if (ir_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", ir_ready); end
    checks++; if ({done, halted, illegal} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b expected 000", {done, halted, illegal}); end
    checks++; if (stat !== 4'h0) begin failures++; $display("FAIL reset_stat: got %b expected 0000", stat); end
    checks++; if (dbg32 !== 32'h0) begin failures++; $display("FAIL reset_reg: got %h expected 0", dbg32); end
    rst_f = 1'b1; #1;
    checks++; if (ir_ready !== 1'b1) begin failures++; $display("FAIL release_ready: got %b expected 1", ir_ready); end
  endtask

  task automatic test_addi;
    int lat; logic dn, rn; logic [31:0] dd;
    dbg_addr = 4'd1;
    exec(32'h2010_0005, lat, dn, rn, dd);
    checks++; if (lat != ALU_LAT) begin failures++; $display("FAIL addi_latency: got %0d expected %0d", lat, ALU_LAT); end
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL done_pulse_width: got %b expected 0", dn); end
    checks++; if (rn !== 1'b1) begin failures++; $display("FAIL ready_after_wb: got %b expected 1", rn); end
    checks++; if (dbg32 !== 32'd5) begin failures++; $display("FAIL addi_r1: got %h expected 5", dbg32); end
    checks++; if (stat !== 4'b0000) begin failures++; $display("FAIL addi_stat: got %b expected 0000", stat); end
  endtask

  task automatic test_sub_zero;
    int lat; logic dn, rn; logic [31:0] dd;
    exec(32'h1121_1000, lat, dn, rn, dd);
    dbg_addr = 4'd2; #1;
    checks++; if (dbg32 !== 32'h0) begin failures++; $display("FAIL sub_r2: got %h expected 0", dbg32); end
    checks++; if (stat !== 4'b1001) begin failures++; $display("FAIL sub_stat: got %b expected 1001", stat); end
  endtask

  task automatic test_overflow16;
    int lat; logic dn, rn; logic [31:0] dd;
    exec(32'h2030_7FFF, lat, dn, rn, dd);
    exec(32'h1043_3000, lat, dn, rn, dd);
    dbg_addr = 4'd4; #1;
    checks++; if (dbg16 !== 16'hFFFE) begin failures++; $display("FAIL add16_r4: got %h expected fffe", dbg16); end
    checks++; if (stat16 !== 4'b0110) begin failures++; $display("FAIL add16_stat: got %b expected 0110", stat16); end
    checks++; if (dbg32 !== 32'h0000_FFFE) begin failures++; $display("FAIL add32_r4: got %h expected 0000fffe", dbg32); end
    checks++; if (stat !== 4'b0000) begin failures++; $display("FAIL add32_stat: got %b expected 0000", stat); end
  endtask

  task automatic test_shift;
    int lat; logic dn, rn; logic [31:0] dd;
    exec(32'h2050_8000, lat, dn, rn, dd);
    exec(32'h2655_0010, lat, dn, rn, dd);
    exec(32'h2355_0001, lat, dn, rn, dd);
    dbg_addr = 4'd5; #1;
    checks++; if (dbg32 !== 32'h8000_0001) begin failures++; $display("FAIL build_r5: got %h expected 80000001", dbg32); end
    exec(32'h2665_0001, lat, dn, rn, dd);
    dbg_addr = 4'd6; #1;
    checks++; if (dbg32 !== 32'h0000_0002) begin failures++; $display("FAIL shl1_res: got %h expected 00000002", dbg32); end
    checks++; if (stat !== 4'b1000) begin failures++; $display("FAIL shl1_stat: got %b expected 1000", stat); end
    exec(32'h2775_0000, lat, dn, rn, dd);
    dbg_addr = 4'd7; #1;
    checks++; if (dbg32 !== 32'h8000_0001) begin failures++; $display("FAIL shr0_res: got %h expected 80000001", dbg32); end
    checks++; if (stat !== 4'b0100) begin failures++; $display("FAIL shr0_stat: got %b expected 0100", stat); end
    exec(32'h2785_0001, lat, dn, rn, dd);
    dbg_addr = 4'd8; #1;
    checks++; if (dbg32 !== 32'h4000_0000) begin failures++; $display("FAIL shr1_res: got %h expected 40000000", dbg32); end
    checks++; if (stat !== 4'b1000) begin failures++; $display("FAIL shr1_stat: got %b expected 1000", stat); end
  endtask

  task automatic test_logic_ops;
    int lat; logic dn, rn; logic [31:0] dd;
    exec(32'h1190_1000, lat, dn, rn, dd);
    dbg_addr = 4'd9; #1;
    checks++; if (dbg32 !== 32'hFFFF_FFFB) begin failures++; $display("FAIL borrow_res: got %h expected fffffffb", dbg32); end
    checks++; if (stat !== 4'b0100) begin failures++; $display("FAIL borrow_stat: got %b expected 0100", stat); end
    exec(32'h15A1_0000, lat, dn, rn, dd);
    dbg_addr = 4'd10; #1;
    checks++; if (dbg32 !== 32'hFFFF_FFFA) begin failures++; $display("FAIL not_res: got %h expected fffffffa", dbg32); end
    exec(32'h24B1_000F, lat, dn, rn, dd);
    dbg_addr = 4'd11; #1;
    checks++; if (dbg32 !== 32'h0000_000A) begin failures++; $display("FAIL xor_res: got %h expected 0000000a", dbg32); end
    checks++; if (stat !== 4'b0000) begin failures++; $display("FAIL xor_stat: got %b expected 0000", stat); end
    exec(32'h22C1_0002, lat, dn, rn, dd);
    checks++; if (stat !== 4'b0001) begin failures++; $display("FAIL and_zero_stat: got %b expected 0001", stat); end
  endtask

  task automatic test_debug_wb;
    int lat; logic dn, rn; logic [31:0] dd;
    dbg_addr = 4'd1;
    exec(32'h2010_0007, lat, dn, rn, dd);
    checks++; if (dd !== 32'd5) begin failures++; $display("FAIL dbg_in_wb: got %h expected 5", dd); end
    checks++; if (dbg32 !== 32'd7) begin failures++; $display("FAIL dbg_after_wb: got %h expected 7", dbg32); end
  endtask

  task automatic test_back_to_back;
    int cyc, first, second;
    logic ready_after;
    first = 0; second = 0; ready_after = 1'b0;
    @(negedge clk);
    ir = 32'h20D0_0001; ir_valid = 1'b1;
    @(posedge clk); #1;
    ir = 32'h5000_0000;
    cyc = 2;
    while (cyc < 24 && second == 0) begin
      if (done === 1'b1) begin
        if (first == 0) begin first = cyc; ir = 32'h20D0_0002; end
        else second = cyc;
      end
      if (first != 0 && cyc == first + 1) ready_after = ir_ready;
      @(posedge clk); #1;
      if (first != 0 && cyc == first + 1) ir_valid = 1'b0;
      cyc++;
    end
    ir_valid = 1'b0;
    dbg_addr = 4'd13; #1;
    checks++; if (first != ALU_LAT) begin failures++; $display("FAIL b2b_first: got %0d expected %0d", first, ALU_LAT); end
    checks++; if (second - first != ALU_LAT) begin failures++; $display("FAIL b2b_gap: got %0d expected %0d", second - first, ALU_LAT); end
    checks++; if (ready_after !== 1'b1) begin failures++; $display("FAIL b2b_ready: got %b expected 1", ready_after); end
    checks++; if (dbg32 !== 32'd2) begin failures++; $display("FAIL b2b_r13: got %h expected 2", dbg32); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL busy_ir_ignored: got %b expected 0", illegal); end
  endtask

  task automatic test_illegal;
    int lat; logic dn, rn; logic [31:0] dd;
    exec(32'h1190_1000, lat, dn, rn, dd);
    exec(32'h5010_0005, lat, dn, rn, dd);
    dbg_addr = 4'd1; #1;
    checks++; if (lat != ILL_LAT) begin failures++; $display("FAIL illegal_done: got %0d expected %0d", lat, ILL_LAT); end
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_flag: got %b expected 1", illegal); end
    checks++; if (stat !== 4'b0100) begin failures++; $display("FAIL illegal_stat: got %b expected 0100", stat); end
    checks++; if (dbg32 !== 32'd7) begin failures++; $display("FAIL illegal_nowrite: got %h expected 7", dbg32); end
    exec(32'h1810_0000, lat, dn, rn, dd);
    checks++; if (lat != ILL_LAT) begin failures++; $display("FAIL badfn_done: got %0d expected %0d", lat, ILL_LAT); end
    checks++; if (dbg32 !== 32'd7) begin failures++; $display("FAIL badfn_nowrite: got %h expected 7", dbg32); end
    exec(32'h20C0_1234, lat, dn, rn, dd);
    dbg_addr = 4'd12; #1;
    checks++; if (dbg32 !== 32'h0000_1234) begin failures++; $display("FAIL after_illegal_r12: got %h expected 1234", dbg32); end
    checks++; if (illegal !== 1'b1) begin failures++; $display("FAIL illegal_sticky: got %b expected 1", illegal); end
  endtask

  task automatic test_halt;
    logic any_done;
    any_done = 1'b0;
    @(negedge clk);
    ir = 32'hF000_0000; ir_valid = 1'b1;
    @(posedge clk); #1;
    ir_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (done === 1'b1) any_done = 1'b1; end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_flag: got %b expected 1", halted); end
    checks++; if (ir_ready !== 1'b0) begin failures++; $display("FAIL halt_ready: got %b expected 0", ir_ready); end
    ir = 32'h20E0_0009; ir_valid = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (done === 1'b1) any_done = 1'b1; end
    ir_valid = 1'b0;
    dbg_addr = 4'd14; #1;
    checks++; if (any_done !== 1'b0) begin failures++; $display("FAIL halt_no_done: got %b expected 0", any_done); end
    checks++; if (dbg32 !== 32'h0) begin failures++; $display("FAIL halt_no_exec: got %h expected 0", dbg32); end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_stays: got %b expected 1", halted); end
  endtask

  task automatic test_reset_mid;
    int lat; logic dn, rn, any_done; logic [31:0] dd;
    @(negedge clk); rst_f = 1'b0;
    @(negedge clk); rst_f = 1'b1;
    dbg_addr = 4'd1; #1;
    checks++; if ({halted, ir_ready} !== 2'b01) begin failures++; $display("FAIL rst_exit_halt: got %b expected 01", {halted, ir_ready}); end
    checks++; if (dbg32 !== 32'h0) begin failures++; $display("FAIL rst_clears_regs: got %h expected 0", dbg32); end
    exec(32'h2010_0003, lat, dn, rn, dd);
    exec(32'h1120_1000, lat, dn, rn, dd);
    exec(32'h5000_0000, lat, dn, rn, dd);
    checks++; if ({stat, illegal} !== 5'b0100_1) begin failures++; $display("FAIL pre_rst_state: got %b expected 01001", {stat, illegal}); end
    @(negedge clk);
    ir = 32'h2010_0055; ir_valid = 1'b1;
    @(posedge clk); #1;
    ir_valid = 1'b0;
    @(posedge clk); #1;
    rst_f = 1'b0; #1;
    dbg_addr = 4'd2; #1;
    checks++; if ({ir_ready, done, halted, illegal} !== 4'b0000) begin failures++; $display("FAIL mid_rst_outputs: got %b expected 0000", {ir_ready, done, halted, illegal}); end
    checks++; if (stat !== 4'h0) begin failures++; $display("FAIL mid_rst_stat: got %b expected 0000", stat); end
    checks++; if (dbg32 !== 32'h0) begin failures++; $display("FAIL mid_rst_r2: got %h expected 0", dbg32); end
    @(negedge clk); rst_f = 1'b1;
    any_done = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (done === 1'b1) any_done = 1'b1; end
    dbg_addr = 4'd1; #1;
    checks++; if (any_done !== 1'b0) begin failures++; $display("FAIL mid_rst_no_done: got %b expected 0", any_done); end
    checks++; if (dbg32 !== 32'h0) begin failures++; $display("FAIL mid_rst_write_lost: got %h expected 0", dbg32); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_addi();
    test_sub_zero();
    test_overflow16();
    test_shift();
    test_logic_ops();
    test_debug_wb();
    test_back_to_back();
    test_illegal();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
